// File: rtl/en_tick_gen.sv
// Run/stop + optional single-step enable-strobe generator for the mod-7 counter stage.
// Optional step button is built only when TICK_STEP_EN is defined.

module en_tick_btn #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    deb_cnt_d    = '0;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    // Only an unbroken run of differing samples reaches the terminal count.
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  assign press = press_q;
endmodule

module en_tick_gen #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic en,
  output logic running
);
  localparam int DIV_W = $clog2(DIV);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic             run_press;
  logic             step_press;
  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             en_q, en_d;

  en_tick_btn #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_run),
    .press (run_press)
  );

`ifdef TICK_STEP_EN
  en_tick_btn #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_step),
    .press (step_press)
  );
`else
  logic unused_btn_step;
  assign unused_btn_step = btn_step;
  assign step_press      = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    en_d      = 1'b0;
    // A run press beats both the terminal count and a simultaneous step press.
    if (run_press) begin
      state_d = ~state_q;
    end else if (state_q == ST_RUN) begin
      if (div_cnt_q == DIV_W'(DIV - 1)) begin
        en_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else begin
      en_d = step_press;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOP;
      div_cnt_q <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      en_q      <= en_d;
    end
  end

  assign en      = en_q;
  assign running = (state_q == ST_RUN);
endmodule
